vehicle_sensor_conditioner: RTL and testbench
=============================================

VEHICLE_SENSOR_CONDITIONER -- requirements
Module: vehicle_sensor_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable synchronized samples needed to accept a detector level change (range 2..255).
REQ-002 Parameter HOLD_CYCLES, default 8: cycles the demand output stays asserted after a qualified vehicle departure (range 1..255).
REQ-003 Parameter STUCK_CYCLES, default 1024: continuous presence cycles after which a detector is declared stuck (range 16..65535).
REQ-004 clk  input  1  single system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clk.
REQ-006 det_a_raw, det_b_raw  input  1 each  asynchronous raw loop-detector levels for streets A and B.
REQ-007 cnt_clr  input  1  synchronous clear of both vehicle counters.
REQ-008 Sa, Sb  output  1 each  registered, conditioned demand outputs; these drive the traffic-light controller's Sa/Sb inputs directly.
REQ-009 fault_a, fault_b  output  1 each  registered stuck-detector flags.
REQ-010 count_a, count_b  output  8 each  saturating vehicle-arrival counters.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchronizer; all logic uses only the synchronized level (sync_x).
REQ-012 Channels A and B SHALL be identical and independent; one channel's activity never affects the other.
REQ-013 Per-channel FSM states: IDLE, ON_QUAL, PRESENT, OFF_QUAL, HOLD, FAULT; one shared 8-bit qualify/hold counter and one 16-bit stuck counter per channel.
REQ-014 IDLE: S=0. sync=1 -> ON_QUAL with counter=1.
REQ-015 ON_QUAL: S=0. sync=1 increments the counter; at the DEB_CYCLES-th consecutive high sample -> PRESENT. sync=0 -> IDLE.
REQ-016 Raw rise stable before edge 0 SHALL produce S=1 registered at edge DEB_CYCLES+2 (latency DEB_CYCLES+2 cycles).
REQ-017 PRESENT: S=1. The stuck counter starts at 0 on entry and increments every cycle in PRESENT or OFF_QUAL. sync=0 -> OFF_QUAL with counter=1.
REQ-018 OFF_QUAL: S=1. At the DEB_CYCLES-th consecutive low sample -> HOLD. sync=1 -> PRESENT; the stuck counter is not reset.
REQ-019 HOLD: S=1 for exactly HOLD_CYCLES cycles, then -> IDLE (S=0). sync=1 in HOLD -> PRESENT; the stuck counter restarts at 0.
REQ-020 Raw fall stable before edge 0, from PRESENT, SHALL produce S=0 registered at edge DEB_CYCLES+HOLD_CYCLES+2.
REQ-021 When the stuck counter reaches STUCK_CYCLES -> FAULT: fault_x=1 and S=1 (fail-safe demand).
REQ-022 FAULT exit: only after DEB_CYCLES consecutive sync=0 samples -> IDLE, with fault_x=0 and S=0 on the same edge; no hold period on fault exit.
REQ-023 count_x SHALL increment by 1 on each ON_QUAL->PRESENT transition, saturate at 255, and never wrap.
REQ-024 HOLD->PRESENT and OFF_QUAL->PRESENT re-entries SHALL NOT increment count_x.
REQ-025 cnt_clr=1 sets both counts to 0 on the next edge; if cnt_clr coincides with an arrival, clear wins and the result is 0.
REQ-026 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.

Reset
REQ-027 reset=0 SHALL asynchronously force: synchronizers=0, FSMs=IDLE, all counters=0, Sa=Sb=0, fault_a=fault_b=0, count_a=count_b=0.
REQ-028 Reset asserted mid-operation, in any state including FAULT, SHALL discard that state; after release, a still-high raw input requalifies from IDLE with full REQ-016 latency.

Verification
REQ-029 Bench uses DEB=4, HOLD=8, STUCK=64, reset released at 20 ns, and covers the following:
- Clean arrival: det_a_raw 0->1 held -> Sa=1 exactly 6 edges later; count_a=1; Sb/fault_b unchanged.
- Glitches: det_a_raw high 3 cycles, then low -> Sa stays 0 and count_a stays 0. Separately, a 2-cycle low dip while PRESENT -> Sa stays 1 and count_a does not increment.
- Departure: det_b_raw 1->0 from PRESENT -> Sb=0 exactly 14 edges later. A 5-cycle re-arrival during HOLD -> Sb stays 1 and count_b does not increment.
- Stuck detector: det_b_raw held high 100 cycles -> fault_b=1 at PRESENT-entry+64 with Sb=1. Release -> fault_b=0 and Sb=0 together 6 edges later.
- Counters: 300 clean arrivals on A -> count_a=255 (saturated). cnt_clr pulsed on the same edge as an arrival -> count_a=0.
- Reset: reset=0 mid-PRESENT with det_a_raw high -> Sa=0 and count_a=0 immediately without a clock edge. After release -> Sa=1 6 edges later.

Source files
------------

// File: rtl/vehicle_sensor_conditioner.sv
// vehicle_sensor_conditioner
// Turns two raw loop-detector levels (streets A and B) into clean, registered
// demand requests for the traffic-light controller. Each channel synchronizes
// its detector and debounces level changes. It holds demand for a while after
// a vehicle leaves, flags a detector that stays on for too long, and counts
// vehicle arrivals.
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous active-low reset
//   det_a_raw, det_b_raw raw detector levels (asynchronous to clk)
//   cnt_clr              synchronous clear of both arrival counters
//   Sa, Sb               conditioned demand outputs (registered)
//   fault_a, fault_b     stuck-detector flags (registered)
//   count_a, count_b     saturating 8-bit arrival counters (registered)
//   state_a, state_b     current channel FSM state, for debug/observation

module vsc_channel #(
    parameter int DEB_CYCLES   = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int STUCK_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det_raw,
    input  logic       cnt_clr,
    output logic       s,
    output logic       fault,
    output logic [7:0] count,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ON_QUAL  = 3'd1,
        PRESENT  = 3'd2,
        OFF_QUAL = 3'd3,
        HOLD     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam logic [7:0]  DEB_LAST   = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES);
    localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES);

    logic [1:0]  sync_q;
    logic        sync;
    state_t      state, next_state;
    logic [7:0]  qcnt, next_qcnt;
    logic [15:0] stuck, next_stuck, stuck_inc;
    logic        arrive;

    assign sync      = sync_q[1];
    assign stuck_inc = stuck + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
            state  <= IDLE;
            qcnt   <= 8'd0;
            stuck  <= 16'd0;
        end else begin
            sync_q <= {sync_q[0], det_raw};
            state  <= next_state;
            qcnt   <= next_qcnt;
            stuck  <= next_stuck;
        end
    end

    // qcnt counts the current sample in the debounce windows (1 = first
    // sample), the hold cycles in HOLD, and the consecutive low samples
    // in FAULT (starting from 0).
    always_comb begin
        next_state = state;
        next_qcnt  = qcnt;
        next_stuck = stuck;
        arrive     = 1'b0;
        case (state)
            IDLE: begin
                if (sync) begin
                    next_state = ON_QUAL;
                    next_qcnt  = 8'd1;
                end
            end
            ON_QUAL: begin
                if (!sync) begin
                    next_state = IDLE;
                    next_qcnt  = 8'd0;
                end else if (qcnt == DEB_LAST) begin
                    next_state = PRESENT;
                    next_qcnt  = 8'd0;
                    next_stuck = 16'd0;
                    arrive     = 1'b1;
                end else begin
                    next_qcnt = qcnt + 8'd1;
                end
            end
            PRESENT: begin
                next_stuck = stuck_inc;
                if (stuck_inc == STUCK_LAST) begin
                    next_state = FAULT;
                    next_qcnt  = 8'd0;
                end else if (!sync) begin
                    next_state = OFF_QUAL;
                    next_qcnt  = 8'd1;
                end
            end
            OFF_QUAL: begin
                next_stuck = stuck_inc;
                if (stuck_inc == STUCK_LAST) begin
                    next_state = FAULT;
                    next_qcnt  = 8'd0;
                end else if (sync) begin
                    // Vehicle still there: resume PRESENT, stuck count carries on.
                    next_state = PRESENT;
                    next_qcnt  = 8'd0;
                end else if (qcnt == DEB_LAST) begin
                    next_state = HOLD;
                    next_qcnt  = 8'd1;
                end else begin
                    next_qcnt = qcnt + 8'd1;
                end
            end
            HOLD: begin
                if (sync) begin
                    next_state = PRESENT;
                    next_qcnt  = 8'd0;
                    next_stuck = 16'd0;
                end else if (qcnt == HOLD_LAST) begin
                    next_state = IDLE;
                    next_qcnt  = 8'd0;
                end else begin
                    next_qcnt = qcnt + 8'd1;
                end
            end
            FAULT: begin
                if (sync) begin
                    next_qcnt = 8'd0;
                end else if (qcnt == DEB_LAST) begin
                    next_state = IDLE;
                    next_qcnt  = 8'd0;
                end else begin
                    next_qcnt = qcnt + 8'd1;
                end
            end
            default: begin
                next_state = IDLE;
                next_qcnt  = 8'd0;
                next_stuck = 16'd0;
            end
        endcase
    end

    // Outputs are registered from the current state, so they trail the state
    // register by one edge. Demand is held in every state except IDLE and
    // ON_QUAL, which makes FAULT a fail-safe demand.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s     <= 1'b0;
            fault <= 1'b0;
            count <= 8'd0;
        end else begin
            s     <= (state != IDLE) && (state != ON_QUAL);
            fault <= (state == FAULT);
            if (cnt_clr)
                count <= 8'd0;
            else if (arrive && (count != 8'hFF))
                count <= count + 8'd1;
        end
    end

    assign state_dbg = state;

endmodule

module vehicle_sensor_conditioner #(
    parameter int DEB_CYCLES   = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int STUCK_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det_a_raw,
    input  logic       det_b_raw,
    input  logic       cnt_clr,
    output logic       Sa,
    output logic       Sb,
    output logic       fault_a,
    output logic       fault_b,
    output logic [7:0] count_a,
    output logic [7:0] count_b,
    output logic [2:0] state_a,
    output logic [2:0] state_b
);

    vsc_channel #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_chan_a (
        .clk      (clk),
        .reset    (reset),
        .det_raw  (det_a_raw),
        .cnt_clr  (cnt_clr),
        .s        (Sa),
        .fault    (fault_a),
        .count    (count_a),
        .state_dbg(state_a)
    );

    vsc_channel #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_chan_b (
        .clk      (clk),
        .reset    (reset),
        .det_raw  (det_b_raw),
        .cnt_clr  (cnt_clr),
        .s        (Sb),
        .fault    (fault_b),
        .count    (count_b),
        .state_dbg(state_b)
    );

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed bench for vehicle_sensor_conditioner (DEB=4, HOLD=8, STUCK=64).
// Inputs change 1 ns after a rising edge; the next rising edge is "edge 0"
// for that change. Outputs are sampled 1 ns after rising edges.
module tb_vehicle_sensor_conditioner;

    logic       clk;
    logic       reset;
    logic       det_a_raw;
    logic       det_b_raw;
    logic       cnt_clr;
    logic       Sa;
    logic       Sb;
    logic       fault_a;
    logic       fault_b;
    logic [7:0] count_a;
    logic [7:0] count_b;
    logic [2:0] state_a;
    logic [2:0] state_b;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    vehicle_sensor_conditioner #(
        .DEB_CYCLES  (4),
        .HOLD_CYCLES (8),
        .STUCK_CYCLES(64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .det_a_raw(det_a_raw),
        .det_b_raw(det_b_raw),
        .cnt_clr  (cnt_clr),
        .Sa       (Sa),
        .Sb       (Sb),
        .fault_a  (fault_a),
        .fault_b  (fault_b),
        .count_a  (count_a),
        .count_b  (count_b),
        .state_a  (state_a),
        .state_b  (state_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One complete vehicle pass on street A, ending back in IDLE.
    task automatic arrive_a();
        det_a_raw = 1'b1;
        wait_edges(8);
        det_a_raw = 1'b0;
        wait_edges(16);
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [15:0] actual,
                            input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b0;
        det_a_raw = 1'b0;
        det_b_raw = 1'b0;
        cnt_clr   = 1'b0;

        #12;
        check_eq("rst_sa", {15'd0, Sa}, 16'd0);
        check_eq("rst_sb", {15'd0, Sb}, 16'd0);
        check_eq("rst_fault_a", {15'd0, fault_a}, 16'd0);
        check_eq("rst_fault_b", {15'd0, fault_b}, 16'd0);
        check_eq("rst_count_a", {8'd0, count_a}, 16'd0);
        check_eq("rst_count_b", {8'd0, count_b}, 16'd0);
        check_eq("rst_state_a", {13'd0, state_a}, 16'd0);
        #8 reset = 1'b1;   // released at 20 ns
        step();

        // Glitch: 3-cycle high pulse must not qualify.
        det_a_raw = 1'b1;
        wait_edges(3);
        det_a_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq("glitch_sa", {15'd0, Sa}, 16'd0);
        end
        check_eq("glitch_count_a", {8'd0, count_a}, 16'd0);
        check_eq("glitch_state_a", {13'd0, state_a}, 16'd0);

        // Clean arrival: Sa rises exactly at edge 6.
        det_a_raw = 1'b1;
        for (int k = 0; k <= 6; k++) exp_q.push_back((k == 6) ? 16'd1 : 16'd0);
        while (exp_q.size() > 0) begin
            step();
            check_eq("arrive_sa", {15'd0, Sa}, exp_q.pop_front());
        end
        check_eq("arrive_count_a", {8'd0, count_a}, 16'd1);
        check_eq("arrive_sb", {15'd0, Sb}, 16'd0);
        check_eq("arrive_fault_b", {15'd0, fault_b}, 16'd0);
        check_eq("arrive_count_b", {8'd0, count_b}, 16'd0);

        // 2-cycle dip while PRESENT: demand stays, no new arrival.
        det_a_raw = 1'b0;
        wait_edges(2);
        det_a_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("dip_sa", {15'd0, Sa}, 16'd1);
        end
        check_eq("dip_count_a", {8'd0, count_a}, 16'd1);

        // Let A depart fully.
        det_a_raw = 1'b0;
        wait_edges(20);
        check_eq("depart_a_sa", {15'd0, Sa}, 16'd0);

        // B arrival, then departure: Sb falls exactly at edge 14.
        det_b_raw = 1'b1;
        wait_edges(8);
        check_eq("arrive_sb_hi", {15'd0, Sb}, 16'd1);
        check_eq("arrive_count_b1", {8'd0, count_b}, 16'd1);
        check_eq("b_indep_sa", {15'd0, Sa}, 16'd0);
        check_eq("b_indep_count_a", {8'd0, count_a}, 16'd1);
        det_b_raw = 1'b0;
        wait_edges(14);
        check_eq("depart_sb_e13", {15'd0, Sb}, 16'd1);
        step();
        check_eq("depart_sb_e14", {15'd0, Sb}, 16'd0);

        // Re-arrival during HOLD: demand never drops, no count.
        det_b_raw = 1'b1;
        wait_edges(8);
        check_eq("rearr_count_b2", {8'd0, count_b}, 16'd2);
        det_b_raw = 1'b0;
        wait_edges(7);
        check_eq("rearr_state_hold", {13'd0, state_b}, 16'd4);
        det_b_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("rearr_sb", {15'd0, Sb}, 16'd1);
        end
        det_b_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("rearr_sb_tail", {15'd0, Sb}, 16'd1);
        end
        check_eq("rearr_count_b", {8'd0, count_b}, 16'd2);
        wait_edges(30);
        check_eq("rearr_sb_end", {15'd0, Sb}, 16'd0);

        // Stuck detector: PRESENT at edge 5, fault at edge 70.
        det_b_raw = 1'b1;
        wait_edges(70);
        check_eq("stuck_fault_e69", {15'd0, fault_b}, 16'd0);
        step();
        check_eq("stuck_fault_e70", {15'd0, fault_b}, 16'd1);
        check_eq("stuck_sb", {15'd0, Sb}, 16'd1);
        check_eq("stuck_count_b", {8'd0, count_b}, 16'd3);
        wait_edges(29);
        det_b_raw = 1'b0;
        wait_edges(6);
        check_eq("unstuck_fault_e5", {15'd0, fault_b}, 16'd1);
        check_eq("unstuck_sb_e5", {15'd0, Sb}, 16'd1);
        step();
        check_eq("unstuck_fault_e6", {15'd0, fault_b}, 16'd0);
        check_eq("unstuck_sb_e6", {15'd0, Sb}, 16'd0);
        check_eq("unstuck_state_b", {13'd0, state_b}, 16'd0);

        // Counter clear and saturation on A.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check_eq("clr_count_a", {8'd0, count_a}, 16'd0);
        check_eq("clr_count_b", {8'd0, count_b}, 16'd0);
        for (int i = 0; i < 254; i++) arrive_a();
        check_eq("count_a_254", {8'd0, count_a}, 16'd254);
        for (int i = 0; i < 46; i++) arrive_a();
        check_eq("count_a_sat", {8'd0, count_a}, 16'd255);

        // Clear on the same edge as an arrival (edge 5): clear wins.
        det_a_raw = 1'b1;
        wait_edges(5);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check_eq("clr_arrive_count", {8'd0, count_a}, 16'd0);
        step();
        check_eq("clr_arrive_sa", {15'd0, Sa}, 16'd1);
        check_eq("clr_arrive_count2", {8'd0, count_a}, 16'd0);

        // Reset mid-PRESENT.
        det_a_raw = 1'b0;
        wait_edges(16);
        det_a_raw = 1'b1;
        wait_edges(8);
        check_eq("pre_rst_sa", {15'd0, Sa}, 16'd1);
        check_eq("pre_rst_count_a", {8'd0, count_a}, 16'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_sa", {15'd0, Sa}, 16'd0);
        check_eq("async_rst_count_a", {8'd0, count_a}, 16'd0);
        check_eq("async_rst_state_a", {13'd0, state_a}, 16'd0);
        #1 reset = 1'b1;
        wait_edges(6);
        check_eq("post_rst_sa_e5", {15'd0, Sa}, 16'd0);
        step();
        check_eq("post_rst_sa_e6", {15'd0, Sa}, 16'd1);
        check_eq("post_rst_count_a", {8'd0, count_a}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
